// File: rtl/stopwatch_uart_ctrl.sv
// UART command controller for the stopwatch: decodes command bytes, drives the per-second tick and serialises "HH:MM:SS\r\n".
// Optional macro STOPWATCH_AUTO_REPORT_EN: each tick seen in IDLE also triggers a report.
module stopwatch_uart_ctrl #(
    parameter int TICK_DIV = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic       sw_en,
    output logic       sw_start,
    output logic       sw_clear,
    output logic       running,
    output logic       busy
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, EXEC, SEND} state_t;

    state_t        state, state_next;
    logic [7:0]    cmd;
    logic [7:0]    cmd_upper;
    logic [5:0]    snap_h, snap_m, snap_s;
    logic [3:0]    idx;
    logic [CW-1:0] count;
    logic          start_next, clear_next, load_report;

    function automatic logic [7:0] report_byte(input logic [3:0] i, input logic [5:0] h,
                                               input logic [5:0] m, input logic [5:0] s);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h30 + 8'(h / 6'd10);
            4'd1:    b = 8'h30 + 8'(h % 6'd10);
            4'd2:    b = 8'h3A;
            4'd3:    b = 8'h30 + 8'(m / 6'd10);
            4'd4:    b = 8'h30 + 8'(m % 6'd10);
            4'd5:    b = 8'h3A;
            4'd6:    b = 8'h30 + 8'(s / 6'd10);
            4'd7:    b = 8'h30 + 8'(s % 6'd10);
            4'd8:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Clearing bit 5 folds lower-case letters onto upper case.
    assign cmd_upper = cmd & 8'hDF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_next  = 1'b0;
        clear_next  = 1'b0;
        load_report = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_next = EXEC;
                end
`ifdef STOPWATCH_AUTO_REPORT_EN
                else if (sw_en) begin
                    load_report = 1'b1;
                    state_next  = SEND;
                end
`endif
            end
            EXEC: begin
                state_next = IDLE;
                case (cmd_upper)
                    8'h53: start_next = 1'b1;
                    8'h47: start_next = ~running;
                    8'h50: start_next = running;
                    8'h43: clear_next = 1'b1;
                    8'h54: begin
                        load_report = 1'b1;
                        state_next  = SEND;
                    end
                    default: ;
                endcase
            end
            SEND: begin
                if (tx_valid && tx_ready && idx == 4'd9) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd      <= 8'h00;
            sw_start <= 1'b0;
            sw_clear <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (state == IDLE && rx_valid) cmd <= rx_data;
            sw_start <= start_next;
            sw_clear <= clear_next;
            busy     <= (state_next != IDLE);
        end
    end

    // running follows the stopwatch's own toggle; a clear overrides both the mode and the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            sw_en   <= 1'b0;
        end else begin
            sw_en <= 1'b0;
            if (clear_next) begin
                running <= 1'b0;
                count   <= '0;
            end else begin
                if (sw_start) running <= ~running;
                if (running) begin
                    if (count == LAST) begin
                        count <= '0;
                        sw_en <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end
        end
    end

    // Byte 0 comes straight from the inputs since the snapshot is loaded on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_h   <= '0;
            snap_m   <= '0;
            snap_s   <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load_report) begin
            snap_h   <= hours;
            snap_m   <= minutes;
            snap_s   <= seconds;
            idx      <= 4'd0;
            tx_valid <= 1'b1;
            tx_data  <= report_byte(4'd0, hours, minutes, seconds);
        end else if (state == SEND) begin
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
                if (idx != 4'd9) begin
                    idx     <= idx + 4'd1;
                    tx_data <= report_byte(idx + 4'd1, snap_h, snap_m, snap_s);
                end
            end else if (!tx_valid) begin
                tx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_uart_ctrl.sv
// Directed self-checking bench for stopwatch_uart_ctrl with TICK_DIV=4.
module tb_stopwatch_uart_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [5:0] hours = 6'd0, minutes = 6'd0, seconds = 6'd0;
    logic       sw_en, sw_start, sw_clear, running, busy;

    int total = 0;
    int bad = 0;
    logic [7:0] got_bytes [10];
    int got_n;

    stopwatch_uart_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sw_en(sw_en), .sw_start(sw_start), .sw_clear(sw_clear),
        .running(running), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns on the negedge of cycle N+1; the following negedge is cycle N+2.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({tx_valid, tx_data, sw_en, sw_start, sw_clear, running, busy} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {tx_valid, tx_data, sw_en, sw_start, sw_clear, running, busy});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_valid, busy, running, sw_en} !== 4'd0) begin
            bad++;
            $display("FAIL after_reset got=%b want=0000", {tx_valid, busy, running, sw_en});
        end
    endtask

    task automatic test_start_prescaler();
        do_reset();
        send_byte(8'h53);
        @(negedge clk);
        total++;
        if (sw_start !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse sw_start=%b running=%b want 1/0", sw_start, running);
        end
        @(negedge clk);
        total++;
        if (sw_start !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL running_rise sw_start=%b running=%b want 0/1", sw_start, running);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (sw_en !== ((k == 4) || (k == 8))) begin
                bad++;
                $display("FAIL tick_k%0d sw_en=%b want=%b", k, sw_en, (k == 4) || (k == 8));
            end
        end
        send_byte(8'h73);
        @(negedge clk);
        total++;
        if (sw_start !== 1'b1) begin
            bad++;
            $display("FAIL stop_pulse sw_start=%b want=1", sw_start);
        end
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL stop_running running=%b want=0", running);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (sw_en !== 1'b0) begin
                bad++;
                $display("FAIL paused_tick_%0d sw_en=%b want=0", k, sw_en);
            end
        end
    endtask

    task automatic test_report();
        logic [7:0] exp [10];
        int first_c;
        exp = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h0D, 8'h0A};
        do_reset();
        hours = 6'd1; minutes = 6'd2; seconds = 6'd3;
        tx_ready = 1'b1;
        got_n = 0;
        first_c = -1;
        send_byte(8'h54);
        for (int c = 0; c < 60 && got_n < 10; c++) begin
            @(negedge clk);
            if (tx_valid && first_c < 0) begin
                first_c = c;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL report_busy busy=%b want=1", busy);
                end
            end
            if (tx_valid && tx_ready) begin
                got_bytes[got_n] = tx_data;
                got_n++;
            end
        end
        total++;
        if (first_c != 0) begin
            bad++;
            $display("FAIL report_latency first_valid_cycle=%0d want=0", first_c);
        end
        total++;
        if (got_n != 10) begin
            bad++;
            $display("FAIL report_count got=%0d want=10", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            total++;
            if (got_bytes[i] !== exp[i]) begin
                bad++;
                $display("FAIL report_byte%0d got=%h want=%h", i, got_bytes[i], exp[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL report_end busy=%b tx_valid=%b want 0/0", busy, tx_valid);
        end
    endtask

    task automatic test_report_stall();
        logic [7:0] exp [10];
        int stalls;
        logic start_seen;
        exp = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
        do_reset();
        hours = 6'd23; minutes = 6'd59; seconds = 6'd59;
        tx_ready = 1'b1;
        got_n = 0;
        stalls = 0;
        start_seen = 1'b0;
        send_byte(8'h74);
        for (int c = 0; c < 80 && got_n < 10; c++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (sw_start) start_seen = 1'b1;
            if (tx_valid && got_n == 3 && stalls < 5) begin
                tx_ready = 1'b0;
                stalls++;
                total++;
                if (tx_data !== 8'h35) begin
                    bad++;
                    $display("FAIL stall_hold%0d tx_data=%h want=35", stalls, tx_data);
                end
                if (stalls == 1) begin
                    hours = 6'd0; minutes = 6'd0; seconds = 6'd0;
                    rx_valid = 1'b1;
                    rx_data = 8'h53;
                end
            end else begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    got_bytes[got_n] = tx_data;
                    got_n++;
                end
            end
        end
        total++;
        if (stalls != 5 || got_n != 10) begin
            bad++;
            $display("FAIL stall_flow stalls=%0d bytes=%0d want 5/10", stalls, got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            total++;
            if (got_bytes[i] !== exp[i]) begin
                bad++;
                $display("FAIL stall_byte%0d got=%h want=%h", i, got_bytes[i], exp[i]);
            end
        end
        @(negedge clk);
        total++;
        if (start_seen !== 1'b0 || running !== 1'b0 || sw_start !== 1'b0) begin
            bad++;
            $display("FAIL send_drop start_seen=%b running=%b want 0/0", start_seen, running);
        end
    endtask

    task automatic test_gp_commands();
        do_reset();
        send_byte(8'h53);
        @(negedge clk);
        @(negedge clk);
        send_byte(8'h47);
        @(negedge clk);
        total++;
        if (sw_start !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL go_while_running sw_start=%b running=%b want 0/1", sw_start, running);
        end
        send_byte(8'h50);
        @(negedge clk);
        total++;
        if (sw_start !== 1'b1) begin
            bad++;
            $display("FAIL pause_pulse sw_start=%b want=1", sw_start);
        end
        @(negedge clk);
        total++;
        if (sw_start !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_state sw_start=%b running=%b want 0/0", sw_start, running);
        end
        send_byte(8'h58);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({sw_start, sw_clear, tx_valid, running, sw_en} !== 5'd0) begin
                bad++;
                $display("FAIL ignore_x_%0d got=%b want=00000", k, {sw_start, sw_clear, tx_valid, running, sw_en});
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        send_byte(8'h53);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL clear_setup running=%b want=1", running);
        end
        send_byte(8'h63);
        @(negedge clk);
        total++;
        if (sw_clear !== 1'b1 || running !== 1'b0 || sw_en !== 1'b0) begin
            bad++;
            $display("FAIL clear_pulse sw_clear=%b running=%b sw_en=%b want 1/0/0", sw_clear, running, sw_en);
        end
        @(negedge clk);
        total++;
        if (sw_clear !== 1'b0 || sw_en !== 1'b0) begin
            bad++;
            $display("FAIL clear_single sw_clear=%b sw_en=%b want 0/0", sw_clear, sw_en);
        end
        send_byte(8'h67);
        @(negedge clk);
        total++;
        if (sw_start !== 1'b1) begin
            bad++;
            $display("FAIL go_pulse sw_start=%b want=1", sw_start);
        end
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            total++;
            if (sw_en !== (j == 4)) begin
                bad++;
                $display("FAIL first_tick_j%0d sw_en=%b want=%b", j, sw_en, j == 4);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int seen;
        do_reset();
        send_byte(8'h53);
        @(negedge clk);
        hours = 6'd12; minutes = 6'd34; seconds = 6'd56;
        tx_ready = 1'b1;
        got_n = 0;
        send_byte(8'h54);
        for (int c = 0; c < 60 && got_n < 5; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                got_bytes[got_n] = tx_data;
                got_n++;
            end
        end
        for (int c = 0; c < 4 && !tx_valid; c++) @(negedge clk);
        total++;
        if (got_n != 5 || got_bytes[4] !== 8'h34 || tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL midsend_setup bytes=%0d byte4=%h tx_valid=%b want 5/34/1", got_n, got_bytes[4], tx_valid);
        end
        reset = 1'b1;
        #1;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL async_reset tx_valid=%b busy=%b running=%b want 0/0/0", tx_valid, busy, running);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_valid || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL no_resume active_cycles=%0d want=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_start_prescaler();
        test_report();
        test_report_stall();
        test_gp_commands();
        test_clear();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
